rfid_receive: RTL and testbench



---
 rtl/rfid_receive.sv | 94 +++++++++
 tb/tb_rfid_receive.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rfid_receive.sv
// rtl/rfid_receive.sv - Uplink RFID frame receiver: delimiter hunt, 128-bit payload, CRC-16/CCITT check.
module rfid_receive (
    input  logic         UL_clock,
    input  logic         reset_n,
    input  logic         UL_data,
    output logic [127:0] packet,
    output logic         packet_rdy
);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CRC} state_t;

    state_t         state, state_nxt;
    logic [3:0]     window;
    logic [7:0]     counter;
    logic [15:0]    crc;
    logic [15:0]    rx_crc;
    logic [127:0]   payload_sr;

    logic [3:0]     window_shifted;
    logic [15:0]    rx_crc_shifted;
    logic [15:0]    crc_next;
    logic           delim_hit;
    logic           payload_done;
    logic           crc_done;

    assign window_shifted = {window[2:0], UL_data};
    assign rx_crc_shifted = {rx_crc[14:0], UL_data};
    assign crc_next       = {crc[14:0], 1'b0} ^ ((crc[15] ^ UL_data) ? 16'h1021 : 16'h0000);
    assign delim_hit      = (window_shifted == 4'b0010);
    assign payload_done   = (counter == 8'd127);
    assign crc_done       = (counter == 8'd15);

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (delim_hit)    state_nxt = PAYLOAD;
            PAYLOAD: if (payload_done) state_nxt = CRC;
            CRC:     if (crc_done)     state_nxt = HUNT;
            default:                   state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge UL_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge UL_clock or negedge reset_n) begin
        if (!reset_n) begin
            window     <= 4'b1111;
            counter    <= 8'd0;
            crc        <= 16'hFFFF;
            rx_crc     <= 16'h0000;
            payload_sr <= 128'h0;
            packet     <= 128'h0;
            packet_rdy <= 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    window <= window_shifted;
                    if (delim_hit) begin
                        counter    <= 8'd0;
                        crc        <= 16'hFFFF;
                        packet_rdy <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    payload_sr <= {payload_sr[126:0], UL_data};
                    crc        <= crc_next;
                    counter    <= payload_done ? 8'd0 : counter + 8'd1;
                end
                CRC: begin
                    rx_crc <= rx_crc_shifted;
                    if (crc_done) begin
                        counter <= 8'd0;
                        // Forcing the window to all-ones demands four fresh bits before the next delimiter.
                        window  <= 4'b1111;
                        if (rx_crc_shifted == crc) begin
                            packet     <= payload_sr;
                            packet_rdy <= 1'b1;
                        end
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rfid_receive.sv
// tb/tb_rfid_receive.sv - Randomized self-checking bench for rfid_receive against a frame-level model.
module tb_rfid_receive;

    logic         UL_clock;
    logic         reset_n;
    logic         UL_data;
    logic [127:0] packet;
    logic         packet_rdy;

    int n_tests;
    int n_fail;
    int stall_pct;

    // Frame-level model: bit history while hunting, collected frame bits otherwise.
    logic         m_collect;
    logic         hist[$];
    logic [143:0] m_frame;
    int           m_nbits;
    logic [127:0] m_packet;
    logic         m_rdy;

    rfid_receive dut (
        .UL_clock   (UL_clock),
        .reset_n    (reset_n),
        .UL_data    (UL_data),
        .packet     (packet),
        .packet_rdy (packet_rdy)
    );

    task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [127:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 127; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic model_reset();
        m_collect = 1'b0;
        hist.delete();
        m_nbits  = 0;
        m_frame  = '0;
        m_packet = '0;
        m_rdy    = 1'b0;
    endtask

    task automatic model_step(input logic b);
        if (!m_collect) begin
            hist.push_back(b);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4 && hist[0] == 1'b0 && hist[1] == 1'b0 &&
                hist[2] == 1'b1 && hist[3] == 1'b0) begin
                m_collect = 1'b1;
                m_nbits   = 0;
                m_rdy     = 1'b0;
            end
        end else begin
            m_frame = {m_frame[142:0], b};
            m_nbits++;
            if (m_nbits == 144) begin
                m_collect = 1'b0;
                hist.delete();
                if (crc16(m_frame[143:16]) == m_frame[15:0]) begin
                    m_packet = m_frame[143:16];
                    m_rdy    = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs(input string where);
        expect_eq({where, ".packet"}, packet, m_packet);
        expect_eq({where, ".rdy"}, {127'h0, packet_rdy}, {127'h0, m_rdy});
    endtask

    // One clock edge: clock idles high, so each bit is a low phase followed by a rising edge.
    task automatic edge_bit(input logic b);
        UL_data  = b;
        UL_clock = 1'b0;
        #5;
        UL_clock = 1'b1;
        model_step(b);
        #1;
        check_outputs("edge");
        #4;
        if (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) begin
            #($urandom_range(40, 5));
            check_outputs("stall");
        end
    endtask

    task automatic send_frame(input logic [127:0] payload, input logic corrupt);
        logic [143:0] bits;
        logic [15:0]  c;
        c = crc16(payload);
        if (corrupt) c[$urandom_range(15, 0)] ^= 1'b1;
        bits = {payload, c};
        edge_bit(1'b0); edge_bit(1'b0); edge_bit(1'b1); edge_bit(1'b0);
        for (int i = 143; i >= 0; i--) edge_bit(bits[i]);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        #9;
        reset_n = 1'b1;
        #5;
    endtask

    initial begin
        logic [127:0] p1, p2, pr;
        n_tests   = 0;
        n_fail    = 0;
        stall_pct = 0;
        UL_clock  = 1'b1;
        UL_data   = 1'b0;
        reset_n   = 1'b0;
        model_reset();
        #10;
        check_outputs("por");
        reset_n = 1'b1;
        #5;

        // Delimiter then idle clock: nothing presented, nothing changes.
        edge_bit(1'b0); edge_bit(1'b0); edge_bit(1'b1); edge_bit(1'b0);
        #100;
        check_outputs("idle_after_delim");
        pulse_reset();

        p1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        send_frame(p1, 1'b0);
        expect_eq("frame1.packet", packet, p1);
        expect_eq("frame1.rdy", {127'h0, packet_rdy}, 128'h1);

        send_frame(p1, 1'b1);
        expect_eq("badcrc.packet", packet, p1);
        expect_eq("badcrc.rdy", {127'h0, packet_rdy}, 128'h0);

        pr = {$urandom, $urandom, $urandom, $urandom};
        send_frame(pr, 1'b0);
        expect_eq("recover.packet", packet, pr);
        expect_eq("recover.rdy", {127'h0, packet_rdy}, 128'h1);

        p2 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        send_frame(p2, 1'b0);
        expect_eq("frame2.packet", packet, p2);
        expect_eq("frame2.rdy", {127'h0, packet_rdy}, 128'h1);

        // Abort mid-payload, then a fresh frame must still be accepted.
        edge_bit(1'b0); edge_bit(1'b0); edge_bit(1'b1); edge_bit(1'b0);
        for (int i = 0; i < 60; i++) edge_bit(1'($urandom_range(1, 0)));
        pulse_reset();
        expect_eq("abort.packet", packet, 128'h0);
        expect_eq("abort.rdy", {127'h0, packet_rdy}, 128'h0);
        send_frame(p1, 1'b0);
        expect_eq("post_abort.packet", packet, p1);
        expect_eq("post_abort.rdy", {127'h0, packet_rdy}, 128'h1);

        // Random frames with random gaps, corruption and clock stalls.
        stall_pct = 3;
        for (int f = 0; f < 25; f++) begin
            int gap;
            gap = $urandom_range(6, 0);
            for (int g = 0; g < gap; g++) edge_bit(1'($urandom_range(1, 0)));
            pr = {$urandom, $urandom, $urandom, $urandom};
            send_frame(pr, ($urandom_range(3, 0) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
